sistema_datapath_exec: RTL



---
 rtl/sistema_datapath_pkg.sv | 48 ++++
 rtl/sistema_alu.sv | 55 +++++
 rtl/sistema_datapath_exec.sv | 144 ++++++++++++++
 3 files changed

// File: rtl/sistema_datapath_pkg.sv
// Shared constants, state type and shift helper for the sistema datapath execution block.
package sistema_datapath_pkg;
    localparam int DW    = 8;
    localparam int NREGS = 4;

    localparam logic [3:0] ALU_ADD  = 4'd0;
    localparam logic [3:0] ALU_SUB  = 4'd1;
    localparam logic [3:0] ALU_AND  = 4'd2;
    localparam logic [3:0] ALU_OR   = 4'd3;
    localparam logic [3:0] ALU_XOR  = 4'd4;
    localparam logic [3:0] ALU_NOTA = 4'd5;
    localparam logic [3:0] ALU_PASA = 4'd6;
    localparam logic [3:0] ALU_PASB = 4'd7;
    localparam logic [3:0] ALU_INC  = 4'd8;
    localparam logic [3:0] ALU_DEC  = 4'd9;
    localparam logic [3:0] ALU_ADC  = 4'd10;

    localparam logic [1:0] SH_NONE = 2'd0;
    localparam logic [1:0] SH_SHL  = 2'd1;
    localparam logic [1:0] SH_SHR  = 2'd2;
    localparam logic [1:0] SH_ROR  = 2'd3;

    localparam logic [2:0] SRC_FIXED0 = 3'd4;
    localparam logic [2:0] SRC_FIXED1 = 3'd5;
    localparam logic [2:0] SRC_IMM    = 3'd6;
    localparam logic [2:0] SRC_ZERO   = 3'd7;

    localparam logic [DW-1:0] FIXED0 = 8'b00001001;
    localparam logic [DW-1:0] FIXED1 = 8'b00001111;

    localparam int FLAG_N = 3;
    localparam int FLAG_Z = 2;
    localparam int FLAG_C = 1;
    localparam int FLAG_V = 0;

    typedef enum logic [2:0] {ST_IDLE, ST_EXEC, ST_SHIFT, ST_WB, ST_RESP} state_t;

    // One shift step: returns {carry, value}; ROR carry is the bit that becomes the MSB.
    function automatic logic [DW:0] shift1(input logic [1:0] op, input logic [DW-1:0] val,
                                           input logic cin);
        case (op)
            SH_SHL:  shift1 = {val[DW-1], val[DW-2:0], 1'b0};
            SH_SHR:  shift1 = {val[0], 1'b0, val[DW-1:1]};
            SH_ROR:  shift1 = {val[0], val[0], val[DW-1:1]};
            default: shift1 = {cin, val};
        endcase
    endfunction
endpackage

// File: rtl/sistema_alu.sv
// Combinational 8-bit ALU; C/V are only meaningful for the arithmetic ops and cleared otherwise.
module sistema_alu
    import sistema_datapath_pkg::*;
(
    input  logic [DW-1:0] a_i,
    input  logic [DW-1:0] b_i,
    input  logic [3:0]    op_i,
    input  logic          cin_i,
    output logic [DW-1:0] y_o,
    output logic          c_o,
    output logic          v_o
);
    logic [DW:0] sum;

    always_comb begin
        sum = '0;
        y_o = '0;
        c_o = 1'b0;
        v_o = 1'b0;
        case (op_i)
            ALU_ADD, ALU_ADC: begin
                sum = {1'b0, a_i} + {1'b0, b_i}
                    + {{DW{1'b0}}, (op_i == ALU_ADC) ? cin_i : 1'b0};
                y_o = sum[DW-1:0];
                c_o = sum[DW];
                v_o = (a_i[DW-1] == b_i[DW-1]) && (y_o[DW-1] != a_i[DW-1]);
            end
            ALU_SUB: begin
                sum = {1'b0, a_i} - {1'b0, b_i};
                y_o = sum[DW-1:0];
                c_o = ~sum[DW];
                v_o = (a_i[DW-1] != b_i[DW-1]) && (y_o[DW-1] != a_i[DW-1]);
            end
            ALU_AND:  y_o = a_i & b_i;
            ALU_OR:   y_o = a_i | b_i;
            ALU_XOR:  y_o = a_i ^ b_i;
            ALU_NOTA: y_o = ~a_i;
            ALU_PASA: y_o = a_i;
            ALU_PASB: y_o = b_i;
            ALU_INC: begin
                sum = {1'b0, a_i} + (DW+1)'(1);
                y_o = sum[DW-1:0];
                c_o = sum[DW];
                v_o = ~a_i[DW-1] & y_o[DW-1];
            end
            ALU_DEC: begin
                sum = {1'b0, a_i} - (DW+1)'(1);
                y_o = sum[DW-1:0];
                c_o = ~sum[DW];
                v_o = a_i[DW-1] & ~y_o[DW-1];
            end
            default: ;
        endcase
    end
endmodule

// File: rtl/sistema_datapath_exec.sv
// Control-word execution datapath: source muxes, ALU, shifter, 4-entry register file, status response.
// Define SISTEMA_DATAPATH_BARREL_SHIFT_EN to finish the shift inside EXEC instead of one bit per cycle.
module sistema_datapath_exec
    import sistema_datapath_pkg::*;
(
    input  logic          CLOCK_50,
    input  logic          Reset_InHigh,
    input  logic          cw_valid,
    output logic          cw_ready,
    input  logic [2:0]    cw_dest,
    input  logic [2:0]    cw_srca,
    input  logic [2:0]    cw_srcb,
    input  logic [3:0]    cw_aluop,
    input  logic [1:0]    cw_shop,
    input  logic [2:0]    cw_shamt,
    input  logic [7:0]    cw_imm,
    output logic          rsp_valid,
    input  logic          rsp_ready,
    output logic [7:0]    rsp_result,
    output logic [3:0]    rsp_flags
);
    state_t                     state_q;
    logic [NREGS-1:0][DW-1:0]   regs_q;
    logic [2:0]                 dest_q;
    logic [3:0]                 aluop_q;
    logic [1:0]                 shop_q;
    logic [2:0]                 cnt_q;
    logic [DW-1:0]              opa_q, opb_q, res_q;
    logic                       c_q, v_q;
    logic                       cw_ready_q, rsp_valid_q;
    logic [DW-1:0]              rsp_result_q;
    logic [3:0]                 flags_q;

    logic [DW-1:0]              srca_d, srcb_d, alu_y;
    logic                       alu_c, alu_v;
    logic [DW:0]                step_d;
    logic [3:0]                 flags_d;

    function automatic logic [DW-1:0] src_sel(input logic [2:0] sel,
                                              input logic [NREGS-1:0][DW-1:0] regs,
                                              input logic [DW-1:0] imm);
        case (sel)
            SRC_FIXED0: src_sel = FIXED0;
            SRC_FIXED1: src_sel = FIXED1;
            SRC_IMM:    src_sel = imm;
            SRC_ZERO:   src_sel = '0;
            default:    src_sel = regs[sel[1:0]];
        endcase
    endfunction

    assign srca_d = src_sel(cw_srca, regs_q, cw_imm);
    assign srcb_d = src_sel(cw_srcb, regs_q, cw_imm);

    // Carry-in comes from the flag register left by the previous instruction.
    sistema_alu u_alu (
        .a_i   (opa_q),
        .b_i   (opb_q),
        .op_i  (aluop_q),
        .cin_i (flags_q[FLAG_C]),
        .y_o   (alu_y),
        .c_o   (alu_c),
        .v_o   (alu_v)
    );

    assign step_d  = shift1(shop_q, res_q, c_q);
    assign flags_d = {res_q[DW-1], (res_q == '0), c_q, v_q};

`ifdef SISTEMA_DATAPATH_BARREL_SHIFT_EN
    logic [DW:0] bar_d;
    always_comb begin
        bar_d = {alu_c, alu_y};
        for (int i = 0; i < 8; i++)
            if (i < int'(cnt_q)) bar_d = shift1(shop_q, bar_d[DW-1:0], bar_d[DW]);
    end
`endif

    always_ff @(posedge CLOCK_50 or posedge Reset_InHigh) begin
        if (Reset_InHigh) begin
            state_q      <= ST_IDLE;
            regs_q       <= '0;
            dest_q       <= '0;
            aluop_q      <= '0;
            shop_q       <= '0;
            cnt_q        <= '0;
            opa_q        <= '0;
            opb_q        <= '0;
            res_q        <= '0;
            c_q          <= 1'b0;
            v_q          <= 1'b0;
            cw_ready_q   <= 1'b1;
            rsp_valid_q  <= 1'b0;
            rsp_result_q <= '0;
            flags_q      <= '0;
        end else begin
            case (state_q)
                ST_IDLE: if (cw_valid) begin
                    dest_q     <= cw_dest;
                    aluop_q    <= cw_aluop;
                    shop_q     <= cw_shop;
                    cnt_q      <= cw_shamt;
                    opa_q      <= srca_d;
                    opb_q      <= srcb_d;
                    cw_ready_q <= 1'b0;
                    state_q    <= ST_EXEC;
                end
                ST_EXEC: begin
                    v_q <= alu_v;
`ifdef SISTEMA_DATAPATH_BARREL_SHIFT_EN
                    res_q   <= bar_d[DW-1:0];
                    c_q     <= bar_d[DW];
                    state_q <= ST_WB;
`else
                    res_q   <= alu_y;
                    c_q     <= alu_c;
                    state_q <= (shop_q != SH_NONE && cnt_q != '0) ? ST_SHIFT : ST_WB;
`endif
                end
                ST_SHIFT: begin
                    {c_q, res_q} <= step_d;
                    cnt_q        <= cnt_q - 3'd1;
                    if (cnt_q == 3'd1) state_q <= ST_WB;
                end
                ST_WB: begin
                    if (!dest_q[2]) regs_q[dest_q[1:0]] <= res_q;
                    flags_q      <= flags_d;
                    rsp_result_q <= res_q;
                    rsp_valid_q  <= 1'b1;
                    state_q      <= ST_RESP;
                end
                ST_RESP: if (rsp_ready) begin
                    rsp_valid_q <= 1'b0;
                    cw_ready_q  <= 1'b1;
                    state_q     <= ST_IDLE;
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign cw_ready   = cw_ready_q;
    assign rsp_valid  = rsp_valid_q;
    assign rsp_result = rsp_result_q;
    assign rsp_flags  = flags_q;
endmodule
